// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES block path.
//   asm_state_t     : assembler FSM states
//   HDR_KEY, HDR_PT : header bytes that tag a frame as key or plaintext
//   AES_BLOCK_BYTES : payload bytes per frame (one 128-bit AES block)
package aes_uart_pkg;

   typedef enum logic [1:0] {
      WAIT_HDR = 2'd0,
      COLLECT  = 2'd1,
      HOLD     = 2'd2
   } asm_state_t;

   localparam logic [7:0] HDR_KEY = 8'h4B;
   localparam logic [7:0] HDR_PT  = 8'h50;

   localparam int AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer. Counts cycles while enabled. The count returns to
// zero whenever clear is high. expire goes high once TIMEOUT_CYC-1 is reached.
// The counter then holds there until it is cleared.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the gap count (byte seen, or timer not in use)
//   enable   : count this cycle
//   expire   : count has reached TIMEOUT_CYC-1
module byte_gap_timer #(
   parameter int TIMEOUT_CYC = 6400
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/uart_block_assembler.sv
// Takes the byte stream from the UART receiver and builds 128-bit AES blocks.
// Each frame is one header byte followed by 16 payload bytes. Header 0x4B
// marks a key and header 0x50 marks plaintext. The finished block is held on a
// valid/ready handshake until the AES core takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_HDR | idle; next byte must be a header, anything else is a frame error
// COLLECT  | shifting payload bytes in; gap timer armed
// HOLD     | block presented; incoming bytes are dropped as overflow
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   byte_in, byte_valid    : received byte and its one-cycle strobe
//   block_out              : assembled block, first payload byte in [127:120]
//   block_is_key           : 1 = key block, 0 = plaintext block
//   block_valid, block_ready : handshake to the AES core
//   frame_error            : one-cycle pulse on bad header or inter-byte timeout
//   overflow               : one-cycle pulse when a byte is dropped in HOLD
module uart_block_assembler
   import aes_uart_pkg::*;
#(
   parameter int CLK_SPEED     = 100_000_000,
   parameter int BAUD_RATE     = 625000,
   parameter int TIMEOUT_BYTES = 4,
   parameter int TIMEOUT_CYC   = TIMEOUT_BYTES * 10 * (CLK_SPEED / BAUD_RATE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   output logic [127:0] block_out,
   output logic         block_is_key,
   output logic         block_valid,
   input  logic         block_ready,
   output logic         frame_error,
   output logic         overflow
);

   localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

   asm_state_t state;
   asm_state_t state_nxt;

   logic [3:0] count;
   logic       kind_key;

   logic hdr_key;
   logic hdr_ok;
   logic tmr_clear;
   logic tmr_en;
   logic tmr_expire;

   logic fe_nxt;
   logic ov_nxt;
   logic bv_nxt;
   logic shift_en;
   logic cnt_clr;
   logic load_kind;
   logic load_key_out;

   assign hdr_key = (byte_in == HDR_KEY);
   assign hdr_ok  = hdr_key || (byte_in == HDR_PT);

   // The timer only runs in COLLECT. A byte on the expiry cycle clears the timer first.
   assign tmr_clear = (state != COLLECT) || byte_valid;
   assign tmr_en    = (state == COLLECT);

   byte_gap_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_HDR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_HDR: begin
            if (byte_valid && hdr_ok) begin
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (byte_valid) begin
               if (count == LAST_IDX) begin
                  state_nxt = HOLD;
               end
            end else if (tmr_expire) begin
               state_nxt = WAIT_HDR;
            end
         end
         HOLD: begin
            if (block_valid && block_ready) begin
               state_nxt = WAIT_HDR;
            end
         end
         default: state_nxt = WAIT_HDR;
      endcase
   end

   always_comb begin
      fe_nxt       = 1'b0;
      ov_nxt       = 1'b0;
      bv_nxt       = 1'b0;
      shift_en     = 1'b0;
      cnt_clr      = 1'b0;
      load_kind    = 1'b0;
      load_key_out = 1'b0;
      case (state)
         WAIT_HDR: begin
            if (byte_valid) begin
               if (hdr_ok) begin
                  load_kind = 1'b1;
                  cnt_clr   = 1'b1;
               end else begin
                  fe_nxt = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (byte_valid) begin
               shift_en = 1'b1;
               if (count == LAST_IDX) begin
                  bv_nxt       = 1'b1;
                  load_key_out = 1'b1;
               end
            end else if (tmr_expire) begin
               fe_nxt  = 1'b1;
               cnt_clr = 1'b1;
            end
         end
         HOLD: begin
            ov_nxt = byte_valid;
            bv_nxt = !block_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         kind_key     <= 1'b0;
         block_out    <= '0;
         block_is_key <= 1'b0;
         block_valid  <= 1'b0;
         frame_error  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         frame_error <= fe_nxt;
         overflow    <= ov_nxt;
         block_valid <= bv_nxt;
         if (load_kind) begin
            kind_key <= hdr_key;
         end
         // The 16th byte wraps count to zero at the same moment the FSM leaves COLLECT.
         if (cnt_clr) begin
            count <= '0;
         end else if (shift_en) begin
            count <= count + 1'b1;
         end
         if (shift_en) begin
            block_out <= {block_out[119:0], byte_in};
         end
         if (load_key_out) begin
            block_is_key <= kind_key;
         end
      end
   end

endmodule

// File: tb/tb_uart_block_assembler.sv
module tb_uart_block_assembler;

   localparam int TIMEOUT_CYC = 4 * 10 * (100_000_000 / 625000);

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic [127:0] block_out;
   logic         block_is_key;
   logic         block_valid;
   logic         block_ready;
   logic         frame_error;
   logic         overflow;

   always #5 clk = ~clk;

   uart_block_assembler dut (
      .clk          (clk),
      .rst          (rst),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .block_out    (block_out),
      .block_is_key (block_is_key),
      .block_valid  (block_valid),
      .block_ready  (block_ready),
      .frame_error  (frame_error),
      .overflow     (overflow)
   );

   typedef struct {
      logic [127:0] data;
      logic         key;
   } blk_t;

   blk_t sb_q[$];
   blk_t exp_blk;

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int hs_cnt   = 0;

   logic         prev_valid = 1'b0;
   logic         prev_hs    = 1'b0;
   logic         prev_fe    = 1'b0;
   logic         prev_ov    = 1'b0;
   logic         prev_key   = 1'b0;
   logic [127:0] prev_out   = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Monitor: handshake scoreboard, hold stability, single-cycle pulses.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
         prev_fe    = 1'b0;
         prev_ov    = 1'b0;
      end else begin
         if (prev_valid && !prev_hs) begin
            check("hold_valid", block_valid, 1);
            check("hold_data", block_out, prev_out);
            check("hold_key", block_is_key, prev_key);
         end
         if (prev_fe) check("fe_single", frame_error, 0);
         if (prev_ov) check("ov_single", overflow, 0);
         if (frame_error) fe_cnt++;
         if (overflow) ov_cnt++;
         if (block_valid && block_ready) begin
            hs_cnt++;
            check("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               exp_blk = sb_q.pop_front();
               check("blk_data", block_out, exp_blk.data);
               check("blk_key", block_is_key, exp_blk.key);
            end
         end
         prev_valid = block_valid;
         prev_hs    = block_valid && block_ready;
         prev_fe    = frame_error;
         prev_ov    = overflow;
         prev_out   = block_out;
         prev_key   = block_is_key;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [7:0] hdr, input logic [127:0] d);
      blk_t e;
      e.data = d;
      e.key  = (hdr == 8'h4B);
      sb_q.push_back(e);
      drive_byte(hdr);
      for (int i = 0; i < 16; i++) drive_byte(d[127-8*i -: 8]);
   endtask

   int fe0, ov0, hs0;
   logic [127:0] d1;

   initial begin
      rst         = 1'b1;
      byte_in     = 8'h00;
      byte_valid  = 1'b0;
      block_ready = 1'b0;
      idle(3);
      check("rst_out", block_out, 0);
      check("rst_key", block_is_key, 0);
      check("rst_valid", block_valid, 0);
      check("rst_fe", frame_error, 0);
      check("rst_ov", overflow, 0);
      rst = 1'b0;
      idle(2);

      // 1: plaintext, ready high, latency and drop after handshake
      block_ready = 1'b1;
      d1 = 128'h000102030405060708090A0B0C0D0E0F;
      exp_blk.data = d1;
      exp_blk.key  = 1'b0;
      sb_q.push_back(exp_blk);
      hs0 = hs_cnt;
      drive_byte(8'h50);
      for (int i = 0; i < 15; i++) drive_byte(d1[127-8*i -: 8]);
      check("t1_valid_early", block_valid, 0);
      drive_byte(d1[7:0]);
      check("t1_valid_lat", block_valid, 1);
      check("t1_key", block_is_key, 0);
      idle(1);
      check("t1_valid_drop", block_valid, 0);
      check("t1_hs", hs_cnt, hs0 + 1);
      idle(2);

      // 2: key block held 20 cycles, single transfer
      block_ready = 1'b0;
      hs0 = hs_cnt;
      send_packet(8'h4B, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
      idle(20);
      check("t2_valid_held", block_valid, 1);
      check("t2_key", block_is_key, 1);
      check("t2_no_hs", hs_cnt, hs0);
      block_ready = 1'b1;
      idle(1);
      block_ready = 1'b0;
      idle(2);
      check("t2_one_hs", hs_cnt, hs0 + 1);
      check("t2_valid_low", block_valid, 0);

      // 3: bad header, then a good packet
      block_ready = 1'b1;
      fe0 = fe_cnt;
      hs0 = hs_cnt;
      drive_byte(8'h41);
      check("t3_fe_now", frame_error, 1);
      idle(3);
      check("t3_fe_cnt", fe_cnt, fe0 + 1);
      check("t3_no_blk", hs_cnt, hs0);
      send_packet(8'h50, 128'hDEADBEEF_01234567_89ABCDEF_55AA33CC);
      idle(3);
      check("t3_hs", hs_cnt, hs0 + 1);

      // 4: partial packet times out exactly TIMEOUT_CYC after the last strobe
      fe0 = fe_cnt;
      hs0 = hs_cnt;
      drive_byte(8'h50);
      for (int i = 0; i < 5; i++) drive_byte(8'hE0 + 8'(i));
      idle(TIMEOUT_CYC - 1);
      check("t4_fe_early", frame_error, 0);
      check("t4_fe_cnt0", fe_cnt, fe0);
      idle(1);
      check("t4_fe_at", frame_error, 1);
      idle(1);
      check("t4_fe_off", frame_error, 0);
      send_packet(8'h50, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
      idle(3);
      check("t4_hs", hs_cnt, hs0 + 1);
      check("t4_fe_cnt1", fe_cnt, fe0 + 1);

      // 5: byte and header injected while holding
      block_ready = 1'b0;
      ov0 = ov_cnt;
      hs0 = hs_cnt;
      send_packet(8'h4B, 128'h00112233445566778899AABBCCDDEEFF);
      idle(2);
      drive_byte(8'hAA);
      check("t5_ov_now", overflow, 1);
      idle(1);
      check("t5_ov_off", overflow, 0);
      check("t5_data", block_out, 128'h00112233445566778899AABBCCDDEEFF);
      drive_byte(8'h50);
      check("t5_ov_hdr", overflow, 1);
      idle(2);
      check("t5_key", block_is_key, 1);
      block_ready = 1'b1;
      idle(1);
      block_ready = 1'b0;
      idle(2);
      check("t5_ov_cnt", ov_cnt, ov0 + 2);
      check("t5_hs", hs_cnt, hs0 + 1);

      // 6: reset mid-packet, then fresh packets including back-to-back
      block_ready = 1'b1;
      drive_byte(8'h50);
      for (int i = 0; i < 8; i++) drive_byte(8'h11 * 8'(i + 1));
      rst = 1'b1;
      idle(1);
      check("t6_rst_out", block_out, 0);
      check("t6_rst_valid", block_valid, 0);
      check("t6_rst_key", block_is_key, 0);
      check("t6_rst_fe", frame_error, 0);
      check("t6_rst_ov", overflow, 0);
      rst = 1'b0;
      idle(1);
      hs0 = hs_cnt;
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      send_packet(8'h4B, 128'hC0FFEE00_12345678_9ABCDEF0_0F1E2D3C);
      idle(1);
      send_packet(8'h50, 128'h6BC1BEE22E409F96E93D7E117393172A);
      idle(1);
      send_packet(8'h4B, 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF);
      idle(3);
      check("t6_hs", hs_cnt, hs0 + 3);
      check("t6_no_ov", ov_cnt, ov0);
      check("t6_no_fe", fe_cnt, fe0);

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_block_assembler.md
Name: uart_block_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (byte plus one-cycle valid strobe).
- Parses framed packets of one header byte and 16 payload bytes, and assembles them into a 128-bit AES block tagged as key or plaintext.
- Presents the block to the AES core over a valid/ready handshake.
- Detects bad headers, inter-byte timeouts and bytes arriving while a block is held.

Parameters:
- CLK_SPEED, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 625000, UART line rate; must match the receiver.
- TIMEOUT_BYTES, 4, allowed inter-byte gap, in 10-bit character times.
- TIMEOUT_CYC, TIMEOUT_BYTES*10*(CLK_SPEED/BAUD_RATE) = 6400, derived gap limit in clk cycles.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- byte_in  input  8  received byte; valid only when byte_valid=1.
- byte_valid  input  1  single-cycle strobe from the receiver.
- block_out  output  128  assembled block; first payload byte in [127:120], last in [7:0].
- block_is_key  output  1  1 = key block (header 0x4B), 0 = plaintext block (header 0x50).
- block_valid  output  1  block_out/block_is_key valid, held until accepted.
- block_ready  input  1  AES core accepts when block_valid & block_ready.
- frame_error  output  1  one-cycle pulse on bad header or timeout.
- overflow  output  1  one-cycle pulse when a byte is dropped in HOLD.

Behaviour:
- Reset (clk, synchronous, active-high rst): state WAIT_HDR, count 0, timer 0; block_out 0, block_is_key 0, block_valid 0, frame_error 0, overflow 0. Reset mid-packet discards all partial data.
- All outputs are registered.
- WAIT_HDR:
  - byte_valid & byte_in==0x4B: kind=key, count=0, timer=0, go to COLLECT.
  - byte_valid & byte_in==0x50: same, with kind=plaintext.
  - byte_valid with any other value: frame_error=1 next cycle; stay in WAIT_HDR.
  - No timer runs in this state.
- COLLECT:
  - On byte_valid: block_out <= {block_out[119:0], byte_in}; count++; timer=0.
  - Byte accepted when count==15: go to HOLD, block_valid=1 in the next cycle (latency: 1 cycle after the 16th strobe); block_is_key updated in that same cycle.
  - No byte_valid: timer++.
  - timer==TIMEOUT_CYC-1 without a byte: frame_error pulse, count=0, go to WAIT_HDR; block_out content is don't-care.
  - byte_valid on the timeout cycle: the byte wins and the timer clears.
- HOLD:
  - block_valid=1; block_out and block_is_key stable.
  - block_valid & block_ready: next cycle block_valid=0, state WAIT_HDR.
  - byte_valid in HOLD (including the handshake cycle): byte dropped, overflow pulse next cycle.
  - Bytes never overwrite a held block.
- Error pulses: frame_error and overflow never stay high more than one cycle per event.
- Widths:
  - count: 4 bits, wraps only via a state change.
  - timer: $clog2(TIMEOUT_CYC) bits, saturates by the state change.
- Back-to-back packets with zero idle between the last payload byte and the next header are legal once HOLD has been exited. A header arriving in HOLD is an overflow.

Decomposition:
- Package aes_uart_pkg holds:
  - the state enum (WAIT_HDR, COLLECT, HOLD);
  - HDR_KEY=8'h4B and HDR_PT=8'h50;
  - AES_BLOCK_BYTES=16.
- One sub-module, byte_gap_timer: clear/enable/expire counter parameterised by TIMEOUT_CYC, reusable by the TX side.

Test Plan:
1. Send 0x50 then bytes 0x00..0x0F, block_ready=1 -> block_valid exactly 1 cycle after the 16th strobe; block_out=128'h000102030405060708090A0B0C0D0E0F; block_is_key=0; valid drops the cycle after the handshake.
2. Send 0x4B then 2B7E151628AED2A6ABF7158809CF4F3C, block_ready=0 for 20 cycles -> block_valid and data stable throughout; block_is_key=1; single transfer when ready rises.
3. Send header 0x41 -> frame_error single pulse, no block_valid; the following valid 0x50 packet assembles correctly.
4. Send 0x50 plus 5 bytes, then idle -> frame_error pulses exactly TIMEOUT_CYC cycles after the 5th strobe; the next full packet yields the correct block with no stale bytes.
5. HOLD with block_ready=0, inject byte 0xAA -> overflow single pulse; block_out unchanged; the block is later delivered intact.
6. Assert rst for 1 cycle after 8 payload bytes -> all outputs 0; a fresh 0x4B packet assembles correctly.
